sound_sequencer: RTL and testbench

- Sequences sample data into the I2S speaker controller.
- Plays a looping background melody fetched beat-by-beat from an external note ROM.
- Arbitrates three game sound-effect (SFX) requests by fixed priority; an SFX preempts the music.
- Outputs 16-bit signed square-wave samples to the speaker controller's audio_in_left/audio_in_right.

---
 rtl/sound_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_sound_sequencer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/sound_sequencer.sv
// sound_sequencer: looping melody plus priority-arbitrated SFX square-wave source.
// Optional build macro SFX_PAN_EN routes rotate/drop effects to a single channel.
module sound_sequencer #(
    parameter int unsigned BEAT_CYCLES = 12500000,
    parameter int unsigned SONG_LEN    = 64,
    parameter int unsigned SFX_BEATS   = 2,
    parameter logic [15:0] AMP         = 16'h2000,
    parameter int unsigned DIV_CLEAR   = 47755,
    parameter int unsigned DIV_DROP    = 381679,
    parameter int unsigned DIV_ROT     = 75873
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [2:0]  sfx_req,
    output logic [2:0]  sfx_ack,
    output logic [5:0]  rom_addr,
    input  logic [21:0] rom_data,
    output logic [15:0] audio_left,
    output logic [15:0] audio_right,
    output logic        sfx_busy,
    output logic [5:0]  beat_idx
);

    localparam int unsigned SFX_CYCLES = BEAT_CYCLES * SFX_BEATS;
    localparam int TW = $clog2(SFX_CYCLES + 1);
    localparam logic [TW-1:0] BEAT_LAST = TW'(BEAT_CYCLES - 1);
    localparam logic [TW-1:0] SFX_LAST  = TW'(SFX_CYCLES - 1);
    localparam logic [5:0]    IDX_LAST  = 6'(SONG_LEN - 1);
    localparam logic [15:0]   NEG_AMP   = ~AMP + 16'd1;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LOAD, S_PLAY, S_SFX
    } state_e;

    state_e        state_q, state_d;
    logic [5:0]    beat_idx_q, beat_idx_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [21:0]   div_q, div_d;
    logic [21:0]   cnt_q, cnt_d;
    logic          phase_q, phase_d;
    logic [2:0]    sfx_q, sfx_d;
    logic [15:0]   left_q, left_d;
    logic [15:0]   right_q, right_d;

    logic [2:0]    win;
    logic [21:0]   win_div;
    logic          take;
    logic          tone_run;
    logic          live;
    logic [15:0]   smp;

    // Pick the highest-priority pending request and decide whether it is taken.
    always_comb begin
        win     = 3'b000;
        win_div = '0;
        priority case (1'b1)
            sfx_req[2]: begin win = 3'b100; win_div = 22'(DIV_CLEAR); end
            sfx_req[1]: begin win = 3'b010; win_div = 22'(DIV_DROP);  end
            sfx_req[0]: begin win = 3'b001; win_div = 22'(DIV_ROT);   end
            default:    begin win = 3'b000; win_div = '0;             end
        endcase
        if (state_q == S_SFX) take = (win > sfx_q);
        else                  take = (win != 3'b000);
    end

    // Next-state, timers, tone generator and sample selection.
    always_comb begin
        state_d    = state_q;
        beat_idx_d = beat_idx_q;
        timer_d    = timer_q;
        div_d      = div_q;
        cnt_d      = cnt_q;
        phase_d    = phase_q;
        sfx_d      = sfx_q;
        sfx_ack    = 3'b000;
        tone_run   = 1'b0;
        live       = 1'b0;
        smp        = '0;
        left_d     = '0;
        right_d    = '0;

        case (state_q)
            S_IDLE: if (en) state_d = S_FETCH;
            S_FETCH: state_d = en ? S_LOAD : S_IDLE;
            S_LOAD: begin
                if (en) begin
                    div_d   = rom_data;
                    cnt_d   = '0;
                    phase_d = 1'b0;
                    timer_d = '0;
                    state_d = S_PLAY;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_PLAY: begin
                if (!en) begin
                    state_d = S_IDLE;
                end else begin
                    tone_run = 1'b1;
                    if (timer_q == BEAT_LAST) begin
                        timer_d    = '0;
                        beat_idx_d = (beat_idx_q == IDX_LAST) ? 6'd0
                                   : beat_idx_q + 6'd1;
                        state_d    = S_FETCH;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
            end
            S_SFX: begin
                tone_run = 1'b1;
                if (timer_q == SFX_LAST) state_d = en ? S_FETCH : S_IDLE;
                else                     timer_d = timer_q + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        if (tone_run) begin
            if (div_q == '0) begin
                cnt_d = '0;
            end else if (cnt_q == div_q - 22'd1) begin
                cnt_d   = '0;
                phase_d = ~phase_q;
            end else begin
                cnt_d = cnt_q + 22'd1;
            end
        end

        // An accepted effect restarts from a clean tone; the beat is kept.
        if (take) begin
            sfx_ack    = win;
            sfx_d      = win;
            div_d      = win_div;
            cnt_d      = '0;
            phase_d    = 1'b0;
            timer_d    = '0;
            beat_idx_d = beat_idx_q;
            state_d    = S_SFX;
        end

        if (state_d == S_IDLE) beat_idx_d = '0;

        live = (state_q == S_PLAY || state_q == S_SFX)
            && (state_d == state_q) && (div_q != '0);
        smp  = phase_q ? AMP : NEG_AMP;
        if (live) begin
            left_d  = smp;
            right_d = smp;
`ifdef SFX_PAN_EN
            if (state_q == S_SFX && sfx_q[0]) right_d = '0;
            if (state_q == S_SFX && sfx_q[1]) left_d  = '0;
`endif
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            beat_idx_q <= '0;
            timer_q    <= '0;
            div_q      <= '0;
            cnt_q      <= '0;
            phase_q    <= 1'b0;
            sfx_q      <= '0;
            left_q     <= '0;
            right_q    <= '0;
        end else begin
            state_q    <= state_d;
            beat_idx_q <= beat_idx_d;
            timer_q    <= timer_d;
            div_q      <= div_d;
            cnt_q      <= cnt_d;
            phase_q    <= phase_d;
            sfx_q      <= sfx_d;
            left_q     <= left_d;
            right_q    <= right_d;
        end
    end

    assign rom_addr    = beat_idx_q;
    assign beat_idx    = beat_idx_q;
    assign audio_left  = left_q;
    assign audio_right = right_q;
    assign sfx_busy    = (state_q == S_SFX);

endmodule

// File: tb/tb_sound_sequencer.sv
// tb_sound_sequencer: directed test of melody playback, SFX arbitration and reset.
// Small timing parameters keep beats and effects short.
module tb_sound_sequencer;

    localparam logic [15:0] AMP  = 16'h2000;
    localparam logic [15:0] NAMP = 16'hE000;
`ifdef SFX_PAN_EN
    localparam bit PAN = 1'b1;
`else
    localparam bit PAN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [2:0]  sfx_req = 3'b000;
    logic [2:0]  sfx_ack;
    logic [5:0]  rom_addr;
    logic [21:0] rom_data = '0;
    logic [15:0] audio_left;
    logic [15:0] audio_right;
    logic        sfx_busy;
    logic [5:0]  beat_idx;
    logic [21:0] rom [64];

    int n_chk = 0;
    int n_fail = 0;

    sound_sequencer #(
        .BEAT_CYCLES(40), .SONG_LEN(4), .SFX_BEATS(2), .AMP(16'h2000),
        .DIV_CLEAR(3), .DIV_DROP(6), .DIV_ROT(5)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .sfx_req(sfx_req),
        .sfx_ack(sfx_ack), .rom_addr(rom_addr), .rom_data(rom_data),
        .audio_left(audio_left), .audio_right(audio_right),
        .sfx_busy(sfx_busy), .beat_idx(beat_idx)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom[rom_addr];

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] sq(input int i, input int h);
        return ((((i - 1) / h) % 2) == 1) ? AMP : NAMP;
    endfunction

    initial begin
        for (int i = 0; i < 64; i++) rom[i] = '0;
        rom[0] = 22'd4;
        rom[1] = 22'd0;
        rom[2] = 22'd2;
        rom[3] = 22'd3;

        // reset state
        tick(3);
        chk("rst_left", audio_left, 0);
        chk("rst_right", audio_right, 0);
        chk("rst_ack", sfx_ack, 0);
        chk("rst_busy", sfx_busy, 0);
        chk("rst_addr", rom_addr, 0);
        chk("rst_idx", beat_idx, 0);
        rst_n = 1'b1;
        tick(2);
        chk("idle_left", audio_left, 0);

        // melody beat 0, half-period 4
        en = 1'b1;
        tick();
        chk("fetch0_addr", rom_addr, 0);
        tick(2);
        chk("p0_left", audio_left, 0);
        for (int i = 1; i <= 12; i++) begin
            tick();
            chk("m0_left", audio_left, sq(i, 4));
            chk("m0_right", audio_right, sq(i, 4));
        end
        tick(27);
        chk("p39_idx", beat_idx, 0);
        tick();
        chk("fetch1_addr", rom_addr, 1);
        chk("fetch1_left", audio_left, 0);

        // beat 1 is a rest
        tick(2);
        for (int i = 0; i < 40; i++) begin
            chk("rest_left", audio_left, 0);
            chk("rest_right", audio_right, 0);
            tick();
        end
        chk("fetch2_addr", rom_addr, 2);

        // beat 2, then drop request with rotate also pending
        tick(7);
        chk("r5_left", audio_left, NAMP);
        sfx_req = 3'b011;
        #1;
        chk("drop_ack", sfx_ack, 3'b010);
        chk("drop_busy_pre", sfx_busy, 0);
        tick();
        chk("drop_ack_once", sfx_ack, 0);
        chk("drop_busy", sfx_busy, 1);
        chk("drop_s0_left", audio_left, 0);
        sfx_req = 3'b000;
        for (int i = 1; i <= 12; i++) begin
            tick();
            chk("drop_left", audio_left, PAN ? 16'h0 : sq(i, 6));
            chk("drop_right", audio_right, sq(i, 6));
        end
        tick(67);
        chk("drop_busy_last", sfx_busy, 1);
        tick();
        chk("drop_end_busy", sfx_busy, 0);
        chk("drop_end_addr", rom_addr, 2);
        chk("drop_end_idx", beat_idx, 2);
        chk("drop_end_left", audio_left, 0);

        // rotate accepted from FETCH, then preempted by line clear
        sfx_req = 3'b001;
        #1;
        chk("rot_ack", sfx_ack, 3'b001);
        tick();
        chk("rot_ack_once", sfx_ack, 0);
        chk("rot_busy", sfx_busy, 1);
        for (int i = 1; i <= 10; i++) begin
            tick();
            chk("rot_left", audio_left, sq(i, 5));
            chk("rot_right", audio_right, PAN ? 16'h0 : sq(i, 5));
        end
        chk("rot_same_noack", sfx_ack, 0);
        sfx_req = 3'b100;
        #1;
        chk("clr_ack", sfx_ack, 3'b100);
        tick();
        sfx_req = 3'b000;
        chk("clr_busy", sfx_busy, 1);
        for (int i = 1; i <= 6; i++) begin
            tick();
            chk("clr_left", audio_left, sq(i, 3));
            chk("clr_right", audio_right, sq(i, 3));
        end
        tick(64);
        en = 1'b0;
        tick(9);
        chk("clr_busy_last", sfx_busy, 1);
        tick();
        chk("clr_end_busy", sfx_busy, 0);
        chk("clr_end_left", audio_left, 0);
        chk("clr_end_right", audio_right, 0);
        chk("clr_end_idx", beat_idx, 0);
        chk("clr_end_addr", rom_addr, 0);

        // full song loop and wrap
        en = 1'b1;
        tick(127);
        chk("fetch3_addr", rom_addr, 3);
        tick(41);
        chk("last_idx", beat_idx, 3);
        tick();
        chk("wrap_addr", rom_addr, 0);
        tick(6);
        chk("wrap_p4_left", audio_left, NAMP);

        // asynchronous reset mid-PLAY
        #2;
        rst_n = 1'b0;
        en = 1'b0;
        #1;
        chk("arst_left", audio_left, 0);
        chk("arst_right", audio_right, 0);
        chk("arst_busy", sfx_busy, 0);
        chk("arst_idx", beat_idx, 0);
        tick(2);
        rst_n = 1'b1;
        tick(3);
        chk("post_rst_left", audio_left, 0);
        chk("post_rst_addr", rom_addr, 0);

        // en drop during PLAY silences next cycle
        en = 1'b1;
        tick(13);
        chk("p10_left", audio_left, NAMP);
        en = 1'b0;
        tick();
        chk("en_off_left", audio_left, 0);
        chk("en_off_right", audio_right, 0);
        chk("en_off_addr", rom_addr, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
